// File: rtl/sdram_arb_pkg.sv
// Shared types and default slot timing for the SDRAM front-end arbiter.
package sdram_arb_pkg;

    typedef enum logic [1:0] {
        GNT_NONE    = 2'd0,
        GNT_REFRESH = 2'd1,
        GNT_VIDEO   = 2'd2,
        GNT_CPU     = 2'd3
    } grant_t;

    localparam int SLOT_LEN_DEF       = 8;
    localparam int CS_HIGH_DEF        = 6;
    localparam int DOUT_PHASE_DEF     = 5;
    localparam int ACK_PHASE_DEF      = 6;
    localparam int REFRESH_CYCLES_DEF = 250;

    // Fixed priority: refresh first so it can never be starved, then video.
    function automatic grant_t pick_grant(input logic rfsh, input logic vid, input logic cpu);
        if (rfsh) return GNT_REFRESH;
        if (vid)  return GNT_VIDEO;
        if (cpu)  return GNT_CPU;
        return GNT_NONE;
    endfunction

endpackage

// File: rtl/sdram_refresh_timer.sv
// Auto-refresh interval timer with a sticky pending flag.
module sdram_refresh_timer #(
    parameter int REFRESH_CYCLES = 250
) (
    input  logic clk,
    input  logic reset,
    input  logic enable,
    input  logic clear,
    output logic pending
);

    localparam int            CW       = $clog2(REFRESH_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(REFRESH_CYCLES - 1);

    logic [CW-1:0] cnt;

    // Count only while the controller is up; an expiry coinciding with a clear wins so no refresh is lost.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt     <= '0;
            pending <= 1'b0;
        end else begin
            if (enable) begin
                if (cnt == CNT_LAST) cnt <= '0;
                else                 cnt <= cnt + 1'b1;
            end
            if (enable && (cnt == CNT_LAST)) pending <= 1'b1;
            else if (clear)                  pending <= 1'b0;
        end
    end

endmodule

// File: rtl/sdram_arbiter.sv
// Slot-based scheduler feeding the SDRAM controller from CPU, video and refresh.
//
// grant        | meaning
// GNT_NONE     | idle slot, ram_cs stays low
// GNT_REFRESH  | auto-refresh slot, no ack
// GNT_VIDEO    | video read, data to vid_dout
// GNT_CPU      | cpu read or write, data to cpu_dout on reads
module sdram_arbiter
    import sdram_arb_pkg::*;
#(
    parameter int SLOT_LEN       = SLOT_LEN_DEF,
    parameter int CS_HIGH        = CS_HIGH_DEF,
    parameter int DOUT_PHASE     = DOUT_PHASE_DEF,
    parameter int ACK_PHASE      = ACK_PHASE_DEF,
    parameter int REFRESH_CYCLES = REFRESH_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ram_ready,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [21:0] cpu_addr,
    input  logic [1:0]  cpu_ds,
    input  logic [15:0] cpu_din,
    output logic [15:0] cpu_dout,
    output logic        cpu_ack,
    input  logic        vid_req,
    input  logic [21:0] vid_addr,
    output logic [15:0] vid_dout,
    output logic        vid_ack,
    output logic        ram_cs,
    output logic        ram_we,
    output logic        ram_refresh,
    output logic [21:0] ram_addr,
    output logic [1:0]  ram_ds,
    output logic [15:0] ram_din,
    input  logic [15:0] ram_dout
);

    localparam int            PW      = $clog2(SLOT_LEN);
    localparam logic [PW-1:0] PH_LAST = PW'(SLOT_LEN - 1);
    localparam logic [PW-1:0] PH_CS   = PW'(CS_HIGH);
    localparam logic [PW-1:0] PH_DOUT = PW'(DOUT_PHASE);
    localparam logic [PW-1:0] PH_ACK  = PW'(ACK_PHASE);

    logic [PW-1:0] phase, phase_nxt;
    grant_t        grant, grant_nxt;
    logic          phase_run, slot_end;
    logic          rfsh_pending, rfsh_clear;

    sdram_refresh_timer #(
        .REFRESH_CYCLES(REFRESH_CYCLES)
    ) u_refresh_timer (
        .clk    (clk),
        .reset  (reset),
        .enable (ram_ready),
        .clear  (rfsh_clear),
        .pending(rfsh_pending)
    );

    // Next phase and grant; a slot already started always runs to its end even if ram_ready drops.
    always_comb begin
        phase_run = ram_ready || (phase != '0);
        slot_end  = phase_run && (phase == PH_LAST);
        phase_nxt = phase;
        grant_nxt = grant;
        if (slot_end) begin
            phase_nxt = '0;
            grant_nxt = ram_ready ? pick_grant(rfsh_pending, vid_req, cpu_req) : GNT_NONE;
        end else if (phase_run) begin
            phase_nxt = phase + 1'b1;
        end else begin
            grant_nxt = GNT_NONE;
        end
        rfsh_clear = slot_end && (grant_nxt == GNT_REFRESH);
    end

    // Registered slot state and every controller/requester output, so nothing is combinational to a port.
    always_ff @(posedge clk) begin
        if (reset) begin
            phase       <= '0;
            grant       <= GNT_NONE;
            ram_cs      <= 1'b0;
            ram_we      <= 1'b0;
            ram_refresh <= 1'b0;
            ram_addr    <= '0;
            ram_ds      <= '0;
            ram_din     <= '0;
            cpu_dout    <= '0;
            cpu_ack     <= 1'b0;
            vid_dout    <= '0;
            vid_ack     <= 1'b0;
        end else begin
            phase   <= phase_nxt;
            grant   <= grant_nxt;
            ram_cs  <= (grant_nxt != GNT_NONE) && (phase_nxt < PH_CS);
            cpu_ack <= (grant_nxt == GNT_CPU)   && (phase_nxt == PH_ACK);
            vid_ack <= (grant_nxt == GNT_VIDEO) && (phase_nxt == PH_ACK);
            if (slot_end) begin
                ram_we      <= 1'b0;
                ram_refresh <= 1'b0;
                ram_addr    <= '0;
                ram_ds      <= '0;
                ram_din     <= '0;
                case (grant_nxt)
                    GNT_CPU: begin
                        ram_we   <= cpu_we;
                        ram_addr <= cpu_addr;
                        ram_ds   <= cpu_ds;
                        ram_din  <= cpu_din;
                    end
                    GNT_VIDEO:   ram_addr    <= vid_addr;
                    GNT_REFRESH: ram_refresh <= 1'b1;
                    default: ;
                endcase
            end
            if (phase_run && (phase == PH_DOUT)) begin
                if ((grant == GNT_CPU) && !ram_we) cpu_dout <= ram_dout;
                if (grant == GNT_VIDEO)            vid_dout <= ram_dout;
            end
        end
    end

endmodule

// File: tb/tb_sdram_arbiter.sv
// Bench for sdram_arbiter: controller model, requester tasks and an ack scoreboard.
module tb_sdram_arbiter;

    localparam int SLOT_LEN   = 8;
    localparam int CS_HIGH    = 6;
    localparam int DOUT_PHASE = 5;
    localparam int ACK_PHASE  = 6;
    localparam int WAIT_LIMIT = 96;

    typedef struct {
        logic        we;
        logic [21:0] addr;
        logic [1:0]  ds;
        logic [15:0] din;
        logic [15:0] data;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset, ram_ready;
    logic        cpu_req, cpu_we, vid_req;
    logic [21:0] cpu_addr, vid_addr;
    logic [1:0]  cpu_ds;
    logic [15:0] cpu_din;
    wire  [15:0] cpu_dout, vid_dout, ram_din, ram_dout;
    wire         cpu_ack, vid_ack, ram_cs, ram_we, ram_refresh;
    wire  [21:0] ram_addr;
    wire  [1:0]  ram_ds;
    wire  [76:0] out_vec;

    exp_t        cpu_q[$];
    exp_t        vid_q[$];
    int          checks = 0, failures = 0;
    int          cyc = 0, tb_phase = 0, slot_cnt = 0;
    int          cpu_slot = 0, vid_slot = 0, rfsh_slot = -1;
    int          rfsh_cnt = 0, last_rfsh_cyc = 0, first_rfsh_cyc = 0;
    logic        rfsh_valid = 1'b0;
    logic        prev_cs = 1'b0;
    logic [15:0] last_rd = '0;

    always #5 clk = ~clk;

    sdram_arbiter dut (
        .clk(clk), .reset(reset), .ram_ready(ram_ready),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_ds(cpu_ds),
        .cpu_din(cpu_din), .cpu_dout(cpu_dout), .cpu_ack(cpu_ack),
        .vid_req(vid_req), .vid_addr(vid_addr), .vid_dout(vid_dout), .vid_ack(vid_ack),
        .ram_cs(ram_cs), .ram_we(ram_we), .ram_refresh(ram_refresh), .ram_addr(ram_addr),
        .ram_ds(ram_ds), .ram_din(ram_din), .ram_dout(ram_dout)
    );

    assign out_vec = {ram_cs, ram_we, ram_refresh, ram_addr, ram_ds, ram_din,
                      cpu_dout, cpu_ack, vid_dout, vid_ack};

    function automatic logic [15:0] ctrl_data(input logic [21:0] a);
        if (a == 22'h012345) return 16'hBEEF;
        return a[15:0] ^ 16'h5A5A;
    endfunction

    // Controller model: read data is valid only during the capture phase of a read slot.
    assign ram_dout = (ram_cs && !ram_we && !ram_refresh && (tb_phase == DOUT_PHASE))
                      ? ctrl_data(ram_addr) : 16'hDEAD;

    task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Independent slot-phase reference.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (reset) tb_phase <= 0;
        else if (ram_ready || tb_phase != 0) begin
            if (tb_phase == SLOT_LEN - 1) begin
                tb_phase <= 0;
                slot_cnt <= slot_cnt + 1;
            end else begin
                tb_phase <= tb_phase + 1;
            end
        end
    end

    task automatic cpu_access(input logic we, input logic [21:0] addr, input logic [1:0] ds,
                              input logic [15:0] din);
        exp_t e;
        int   n;
        e.we = we; e.addr = addr; e.ds = ds; e.din = din; e.data = ctrl_data(addr);
        cpu_q.push_back(e);
        cpu_we = we; cpu_addr = addr; cpu_ds = ds; cpu_din = din; cpu_req = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (!cpu_ack && n < WAIT_LIMIT);
        if (!cpu_ack) check_val("cpu_ack_timeout", 128'(cpu_ack), 128'(1));
        cpu_req = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic vid_access(input logic [21:0] addr);
        exp_t e;
        int   n;
        e.we = 1'b0; e.addr = addr; e.ds = 2'b00; e.din = '0; e.data = ctrl_data(addr);
        vid_q.push_back(e);
        vid_addr = addr; vid_req = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (!vid_ack && n < WAIT_LIMIT);
        if (!vid_ack) check_val("vid_ack_timeout", 128'(vid_ack), 128'(1));
        vid_req = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    // Output monitor: pops the scoreboard on each ack and checks slot framing.
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (reset || !ram_ready) rfsh_valid = 1'b0;
            if (reset) begin
                last_rd = '0;
            end else begin
                if (ram_cs) check_val("cs_phase", 128'(tb_phase < CS_HIGH), 128'(1));
                if (tb_phase >= 1 && tb_phase < CS_HIGH)
                    check_val("cs_stable", 128'(ram_cs), 128'(prev_cs));
                if (cpu_ack) begin
                    check_val("cpu_ack_phase", 128'(tb_phase), 128'(ACK_PHASE));
                    check_val("one_ack_per_slot", 128'(vid_ack), 128'(0));
                    if (cpu_q.size() == 0) begin
                        check_val("cpu_spurious_ack", 128'(cpu_ack), 128'(0));
                    end else begin
                        e = cpu_q.pop_front();
                        check_val("cpu_addr", 128'(ram_addr), 128'(e.addr));
                        check_val("cpu_we", 128'(ram_we), 128'(e.we));
                        if (e.we) begin
                            check_val("cpu_ds", 128'(ram_ds), 128'(e.ds));
                            check_val("cpu_din", 128'(ram_din), 128'(e.din));
                            check_val("cpu_dout_hold", 128'(cpu_dout), 128'(last_rd));
                        end else begin
                            check_val("cpu_dout", 128'(cpu_dout), 128'(e.data));
                            last_rd = e.data;
                        end
                    end
                    cpu_slot = slot_cnt;
                end
                if (vid_ack) begin
                    check_val("vid_ack_phase", 128'(tb_phase), 128'(ACK_PHASE));
                    if (vid_q.size() == 0) begin
                        check_val("vid_spurious_ack", 128'(vid_ack), 128'(0));
                    end else begin
                        e = vid_q.pop_front();
                        check_val("vid_addr", 128'(ram_addr), 128'(e.addr));
                        check_val("vid_we_ds", 128'({ram_we, ram_ds}), 128'(0));
                        check_val("vid_dout", 128'(vid_dout), 128'(e.data));
                    end
                    vid_slot = slot_cnt;
                end
                if (ram_refresh && ram_cs && tb_phase == 0) begin
                    check_val("refresh_we", 128'(ram_we), 128'(0));
                    if (rfsh_valid)
                        check_val("refresh_interval",
                                  128'((cyc - last_rfsh_cyc) inside {[242:258]}), 128'(1));
                    if (rfsh_cnt == 0) first_rfsh_cyc = cyc;
                    last_rfsh_cyc = cyc;
                    rfsh_valid    = 1'b1;
                    rfsh_cnt++;
                    rfsh_slot = slot_cnt;
                end
                if (ram_refresh && tb_phase == ACK_PHASE)
                    check_val("refresh_no_ack", 128'(cpu_ack | vid_ack), 128'(0));
            end
            prev_cs = ram_cs;
        end
    end

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        int cs_seen, n, r0, rise_cyc;
        reset = 1'b1; ram_ready = 1'b0;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_ds = '0; cpu_din = '0;
        vid_req = 1'b0; vid_addr = '0;
        repeat (3) @(negedge clk);
        check_val("reset_outputs", 128'(out_vec), 128'(0));
        reset = 1'b0;

        // Controller not ready: nothing may be issued.
        cs_seen = 0;
        repeat (100) begin @(negedge clk); if (ram_cs) cs_seen++; end
        check_val("no_cs_not_ready", 128'(cs_seen), 128'(0));
        ram_ready = 1'b1;
        rise_cyc  = cyc;

        cpu_access(1'b0, 22'h012345, 2'b00, 16'h0000);
        cpu_access(1'b1, 22'h000777, 2'b01, 16'h1234);
        cpu_access(1'b0, 22'h3FFFFF, 2'b00, 16'h0000);

        fork
            vid_access(22'h00A000);
            cpu_access(1'b0, 22'h000100, 2'b00, 16'h0000);
        join
        check_val("vid_then_cpu_slot", 128'(cpu_slot),
                  128'(vid_slot + 1 + ((rfsh_slot == vid_slot + 1) ? 1 : 0)));

        n = 0;
        while (rfsh_cnt == 0 && n < 400) begin @(negedge clk); n++; end
        check_val("first_refresh_delay",
                  128'((first_rfsh_cyc - rise_cyc) inside {[250:258]}), 128'(1));

        // Both requesters busy: refresh must still get through.
        r0 = rfsh_cnt;
        fork
            begin
                for (int i = 0; i < 35; i++) vid_access(22'($urandom));
            end
            begin
                for (int j = 0; j < 35; j++)
                    cpu_access(1'($urandom), 22'($urandom), 2'($urandom), 16'($urandom));
            end
        join
        check_val("refresh_under_load", 128'((rfsh_cnt - r0) >= 2), 128'(1));

        // ram_ready falls mid-slot: the slot finishes with its ack, then the arbiter parks.
        fork
            cpu_access(1'b0, 22'h155555, 2'b00, 16'h0000);
            begin : drop_wait
                int w;
                w = 0;
                while (!(ram_cs && tb_phase == 2 && !ram_refresh && ram_addr == 22'h155555)
                       && w < WAIT_LIMIT) begin
                    @(negedge clk); w++;
                end
                check_val("ready_drop_slot_found", 128'(ram_cs && tb_phase == 2), 128'(1));
                ram_ready = 1'b0;
            end
        join
        cs_seen = 0;
        repeat (100) begin @(negedge clk); if (ram_cs) cs_seen++; end
        check_val("no_cs_after_ready_drop", 128'(cs_seen), 128'(0));
        ram_ready = 1'b1;

        // Reset at phase 3 of a CPU read: outputs clear, the read is re-served afterwards.
        fork
            cpu_access(1'b0, 22'h0ABCDE, 2'b00, 16'h0000);
            begin : rst_wait
                int w;
                w = 0;
                while (!(ram_cs && tb_phase == 3 && ram_addr == 22'h0ABCDE) && w < WAIT_LIMIT) begin
                    @(negedge clk); w++;
                end
                reset = 1'b1;
                @(negedge clk);
                check_val("reset_mid_slot_outputs", 128'(out_vec), 128'(0));
                @(negedge clk);
                reset = 1'b0;
            end
        join

        repeat (20) @(negedge clk);
        check_val("cpu_queue_empty", 128'(cpu_q.size()), 128'(0));
        check_val("vid_queue_empty", 128'(vid_q.size()), 128'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
